softmax_sub_ctrl: RTL and testbench
===================================

# softmax_sub_ctrl

Sequencer for the softmax "x − max" stage. It accepts a vector descriptor and the vector maximum from the max-finder, then arms the Q7.8 subtractor FSMD with the maximum. It owns the element counter that the subtractor reads back, and fetches each element from the input buffer on the subtractor's request. Results are forwarded to the exp stage, and the controller signals completion when the subtractor flags the last result.

## Interface
- `count_width`, 8: width of element counter, buffer address and vector length; must match the subtractor's `count_width`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset; shared with the subtractor.
- `start_i`  in  1  one-cycle pulse: begin a vector; ignored while `busy_o`=1.
- `vec_len_i`  in  count_width  number of elements, 1..2^count_width−1; sampled on `start_i`.
- `max_valid_i`  in  1  max-finder result valid; level, held until acked.
- `max_i`  in  16  Q7.8 vector maximum.
- `max_ack_o`  out  1  one-cycle pulse: `max_i` latched.
- `rd_en_o`  out  1  buffer read strobe; data returns the next cycle.
- `rd_addr_o`  out  count_width  buffer read address.
- `rd_data_i`  in  16  buffer read data, valid the cycle after `rd_en_o`.
- `sub_data2_en_o`  out  1  one-cycle pulse to subtractor `data2_en`.
- `sub_data2_o`  out  16  latched maximum, to subtractor `data2_i`.
- `sub_data1_req_i`  in  1  subtractor `data1_req`.
- `sub_data1_en_o`  out  1  to subtractor `data1_en`; element held valid.
- `sub_data1_o`  out  16  held element, to subtractor `data1_i`.
- `sub_count_o`  out  count_width  element counter, to subtractor `count_i`.
- `sub_last_count_o`  out  count_width  latched `vec_len_i`, to subtractor `last_count`.
- `sub_ready_o`  out  1  to subtractor `ready`; equals `ds_ready_i` while in STREAM, else 0.
- `sub_outc_i`  in  1  subtractor `outc`: counter-increment pulse.
- `sub_valid_i`, `sub_data_i`, `sub_last_i`  in  1/16/1  subtractor `data_valid_o`/`data_o`/`last`.
- `ds_ready_i`  in  1  downstream (exp stage) can accept a new element.
- `res_valid_o`, `res_data_o`, `res_last_o`  out  1/16/1  combinational pass-through of `sub_valid_i`/`sub_data_i`/`sub_last_i`.
- `busy_o`  out  1  high from the accepted `start_i` until `done_o`.
- `done_o`  out  1  one-cycle pulse: vector complete.
- `err_o`  out  1  one-cycle pulse: `start_i` with `vec_len_i`=0.

## Operation
- States: IDLE → WAIT_MAX → ARM → STREAM → IDLE.
- IDLE:
  - On `start_i` with len≠0: latch len into `sub_last_count_o`, clear counter, go to WAIT_MAX, set `busy_o`.
  - On `start_i` with len=0: pulse `err_o` next cycle and stay in IDLE.
- WAIT_MAX: on `max_valid_i`, latch `max_i`, pulse `max_ack_o`, go to ARM.
- ARM: drive `sub_data2_en_o`=1 for exactly one cycle with `sub_data2_o`=max, then go to STREAM.
- STREAM, fetch:
  - `rd_en_o` = STREAM & `sub_data1_req_i` & !elem_valid & !rd_pend & !`sub_outc_i` (combinational).
  - `rd_addr_o` = counter.
  - rd_pend is set the cycle after `rd_en_o`. In that cycle, latch `rd_data_i` into `sub_data1_o`, set elem_valid and clear rd_pend.
  - `sub_data1_en_o` = elem_valid.
- STREAM, accept: on `sub_outc_i`, counter += 1 and elem_valid is cleared. The element stays stable through the `sub_outc_i` cycle, because the subtractor samples `data1_i` in that cycle.
- STREAM, exit: on `sub_valid_i & sub_last_i`, go to IDLE, pulse `done_o` the next cycle, drop `busy_o`.
- `start_i` and `max_valid_i` are ignored outside IDLE and WAIT_MAX respectively.
- `sub_outc_i` outside STREAM is ignored and the counter is unchanged.
- The controller does no arithmetic. Saturation and wrap are the subtractor's `SATURATE` setting, passed through untouched.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, elem_valid 0, rd_pend 0, latched max and length 0.
- Start to first fetch: `start_i`@t0 with `max_valid_i` already high gives:
  - `max_ack_o`@t1
  - `sub_data2_en_o`@t2
  - subtractor request high from t3
  - `rd_en_o`@t3 (addr 0)
  - `sub_data1_en_o`@t5
- Steady state with `ds_ready_i`=1: one element per 4 cycles.
  - rd_en@r, data1_en@r+2, `sub_outc_i`@r+3.
  - Next rd_en@r+4, coincident with the result `res_valid_o`@r+4.
- `ds_ready_i`=0: the element is held with `sub_data1_en_o`=1 and no counter change until ready returns.
- Last element: `res_last_o`=1 with the final `res_valid_o`; `done_o` the next cycle; `sub_data1_req_i` falls, so no further reads.
- Length 2^count_width−1: counter reaches len and never wraps within a vector.
- Reset asserted mid-vector: immediate return to IDLE with all outputs 0; the subtractor resets on the same `rst_n`.

## Test plan
- Basic: max=0x0200, len=3, buffer {0x0300,0x0100,0x0200} -> results 0x0100, 0xFF00, 0x0000. `res_last_o` on the third result, `done_o` one cycle later, reads at addrs 0,1,2 only.
- Saturation (subtractor `SATURATE`=1): max=0x0100, element 0x8000 -> 0x8000. Max=0xFF00, element 0x7FF0 -> 0x7FFF.
- Backpressure: `ds_ready_i`=0 for 10 cycles after the first element becomes valid -> no `sub_outc_i`, counter stays 0, `sub_data1_o` stable; resumes within 1 cycle of ready.
- Late max: `start_i`, then `max_valid_i` after 7 cycles -> no `sub_data2_en_o` until `max_ack_o`; `start_i` repeated while busy is ignored (single `done_o`).
- Zero length: `start_i` with len=0 -> `err_o` pulse, `busy_o` stays 0, no reads.
- Reset mid-stream: assert `rst_n` low after 2 of 5 results -> all outputs 0; a fresh start with len=1 completes correctly.

Source files
------------

// File: rtl/softmax_sub_ctrl_if.sv
// softmax_sub_ctrl_if: link between the x-max sequencer
// and the Q7.8 subtractor FSMD.
interface softmax_sub_ctrl_if #(
  parameter int count_width = 8
);
  logic                   sub_data2_en_o;
  logic [15:0]            sub_data2_o;
  logic                   sub_data1_req_i;
  logic                   sub_data1_en_o;
  logic [15:0]            sub_data1_o;
  logic [count_width-1:0] sub_count_o;
  logic [count_width-1:0] sub_last_count_o;
  logic                   sub_ready_o;
  logic                   sub_outc_i;
  logic                   sub_valid_i;
  logic [15:0]            sub_data_i;
  logic                   sub_last_i;

  modport master (
    output sub_data2_en_o,
    output sub_data2_o,
    output sub_data1_en_o,
    output sub_data1_o,
    output sub_count_o,
    output sub_last_count_o,
    output sub_ready_o,
    input  sub_data1_req_i,
    input  sub_outc_i,
    input  sub_valid_i,
    input  sub_data_i,
    input  sub_last_i
  );

  modport slave (
    input  sub_data2_en_o,
    input  sub_data2_o,
    input  sub_data1_en_o,
    input  sub_data1_o,
    input  sub_count_o,
    input  sub_last_count_o,
    input  sub_ready_o,
    output sub_data1_req_i,
    output sub_outc_i,
    output sub_valid_i,
    output sub_data_i,
    output sub_last_i
  );
endinterface

// File: rtl/softmax_sub_ctrl.sv
// softmax_sub_ctrl: sequences the softmax x-max stage,
// arming the subtractor and feeding it buffer elements.
module softmax_sub_ctrl #(
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [count_width-1:0] vec_len_i,
  input  logic                   max_valid_i,
  input  logic [15:0]            max_i,
  output logic                   max_ack_o,
  output logic                   rd_en_o,
  output logic [count_width-1:0] rd_addr_o,
  input  logic [15:0]            rd_data_i,
  softmax_sub_ctrl_if.master     sif,
  input  logic                   ds_ready_i,
  output logic                   res_valid_o,
  output logic [15:0]            res_data_o,
  output logic                   res_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MAX,
    ARM,
    STREAM
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [count_width-1:0] cnt;
  logic [count_width-1:0] last_cnt;
  logic [15:0]            max_q;
  logic [15:0]            elem_q;
  logic                   elem_valid;
  logic                   rd_pend;
  logic                   done_q;
  logic                   err_q;
  logic                   in_stream;
  logic                   arm;
  logic                   finish;
  logic                   start_ok;
  logic                   start_bad;

  assign in_stream = (state == STREAM);
  assign start_ok  = (state == IDLE) & start_i
                   & (vec_len_i != '0);
  assign start_bad = (state == IDLE) & start_i
                   & (vec_len_i == '0);

  always_comb begin
    state_nx  = state;
    max_ack_o = 1'b0;
    arm       = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nx = WAIT_MAX;
      end
      WAIT_MAX: begin
        if (max_valid_i) begin
          max_ack_o = 1'b1;
          state_nx  = ARM;
        end
      end
      ARM: begin
        arm      = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        if (sif.sub_valid_i & sif.sub_last_i) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A fetch waits while the current element is still being consumed
  assign rd_en_o = in_stream & sif.sub_data1_req_i
                 & ~elem_valid & ~rd_pend
                 & ~sif.sub_outc_i;
  assign rd_addr_o = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      last_cnt   <= '0;
      max_q      <= '0;
      elem_q     <= '0;
      elem_valid <= 1'b0;
      rd_pend    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q  <= finish;
      err_q   <= start_bad;
      rd_pend <= rd_en_o;
      if (start_ok) begin
        last_cnt <= vec_len_i;
        cnt      <= '0;
      end
      if (max_ack_o) max_q <= max_i;
      if (rd_pend) begin
        elem_q     <= rd_data_i;
        elem_valid <= 1'b1;
      end
      if (in_stream & sif.sub_outc_i) begin
        cnt        <= cnt + 1'b1;
        elem_valid <= 1'b0;
      end
      if (finish) begin
        elem_valid <= 1'b0;
        rd_pend    <= 1'b0;
      end
    end
  end

  assign sif.sub_data2_en_o   = arm;
  assign sif.sub_data2_o      = max_q;
  assign sif.sub_data1_en_o   = elem_valid;
  assign sif.sub_data1_o      = elem_q;
  assign sif.sub_count_o      = cnt;
  assign sif.sub_last_count_o = last_cnt;
  assign sif.sub_ready_o      = in_stream & ds_ready_i;

  assign res_valid_o = sif.sub_valid_i;
  assign res_data_o  = sif.sub_data_i;
  assign res_last_o  = sif.sub_last_i;

  assign busy_o = (state != IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_softmax_sub_ctrl.sv
// tb_softmax_sub_ctrl: drives softmax_sub_ctrl against a
// saturating subtractor model and a buffer memory.
module tb_softmax_sub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  vec_len_i;
  logic        max_valid_i;
  logic [15:0] max_i;
  logic        max_ack_o;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [15:0] rd_data_i;
  logic        ds_ready_i;
  logic        res_valid_o;
  logic [15:0] res_data_o;
  logic        res_last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  softmax_sub_ctrl_if #(.count_width(8)) sif ();

  softmax_sub_ctrl #(.count_width(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .vec_len_i   (vec_len_i),
    .max_valid_i (max_valid_i),
    .max_i       (max_i),
    .max_ack_o   (max_ack_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .sif         (sif),
    .ds_ready_i  (ds_ready_i),
    .res_valid_o (res_valid_o),
    .res_data_o  (res_data_o),
    .res_last_o  (res_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] ref_sub(
    input logic [15:0] x, input logic [15:0] m);
    int d;
    d = int'($signed(x)) - int'($signed(m));
    if (d > 32767) return 16'h7fff;
    if (d < -32768) return 16'h8000;
    return d[15:0];
  endfunction

  // Buffer memory: one-cycle read latency
  logic [15:0] mem [256];
  always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  // Subtractor model: consume, then result one cycle later
  logic        armed, outc_q, v_q, l_q;
  logic [15:0] smax, d_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 0; outc_q <= 0; v_q <= 0; l_q <= 0;
      smax <= '0; d_q <= '0;
    end else begin
      outc_q <= 0; v_q <= 0; l_q <= 0;
      if (sif.sub_data2_en_o) begin
        smax <= sif.sub_data2_o; armed <= 1;
      end
      if (armed && sif.sub_data1_en_o
          && sif.sub_ready_o && !outc_q) outc_q <= 1;
      if (outc_q) begin
        d_q <= ref_sub(sif.sub_data1_o, smax);
        v_q <= 1;
        l_q <= (sif.sub_count_o
                == 8'(sif.sub_last_count_o - 8'd1));
      end
      if (v_q && l_q) armed <= 0;
    end
  end
  assign sif.sub_data1_req_i =
    armed && (sif.sub_count_o < sif.sub_last_count_o);
  assign sif.sub_outc_i  = outc_q;
  assign sif.sub_valid_i = v_q;
  assign sif.sub_data_i  = d_q;
  assign sif.sub_last_i  = l_q;

  // Event monitor, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int clr_gen = 0;
  int seen_gen = 0;
  int t_start, t_ack, t_d2, t_d1en, done_cyc;
  int ack_n, d2_n, done_n, err_n, outc_n, busy_n;
  int rd_q[$], rd_cyc[$], res_q[$], lst_q[$], res_cyc[$];

  always @(negedge clk) begin
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      t_start = -1; t_ack = -1; t_d2 = -1; t_d1en = -1;
      done_cyc = -1;
      ack_n = 0; d2_n = 0; done_n = 0; err_n = 0;
      outc_n = 0; busy_n = 0;
      rd_q.delete(); rd_cyc.delete();
      res_q.delete(); lst_q.delete(); res_cyc.delete();
    end
    if (start_i && t_start < 0) t_start = cyc;
    if (max_ack_o) begin
      ack_n++; if (t_ack < 0) t_ack = cyc;
    end
    if (sif.sub_data2_en_o) begin
      d2_n++; if (t_d2 < 0) t_d2 = cyc;
    end
    if (sif.sub_data1_en_o && t_d1en < 0) t_d1en = cyc;
    if (rd_en_o) begin
      rd_q.push_back(int'(rd_addr_o));
      rd_cyc.push_back(cyc);
    end
    if (res_valid_o) begin
      res_q.push_back(int'(res_data_o));
      lst_q.push_back(int'(res_last_o));
      res_cyc.push_back(cyc);
    end
    if (done_o) begin done_n++; done_cyc = cyc; end
    if (err_o) err_n++;
    if (sif.sub_outc_i) outc_n++;
    if (busy_o) busy_n++;
  end

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [81:0] outs();
    return {max_ack_o, rd_en_o, rd_addr_o,
            sif.sub_data2_en_o, sif.sub_data2_o,
            sif.sub_data1_en_o, sif.sub_data1_o,
            sif.sub_count_o, sif.sub_last_count_o,
            sif.sub_ready_o, res_valid_o, res_data_o,
            res_last_o, busy_o, done_o, err_o};
  endfunction

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int len, input logic [15:0] mx,
                         input int mdly, input bit rnd,
                         input bit bp, input bit tim,
                         input bit restart);
    int k;
    int last;
    logic [15:0] held;
    clr_gen++;
    ds_ready_i = !bp;
    step;
    start_i = 1; vec_len_i = 8'(len);
    max_i = mx; max_valid_i = (mdly == 0);
    step;
    start_i = 0;
    if (mdly > 0) begin
      repeat (mdly) step;
      chk("no_d2_before_max", d2_n, 0);
      chk("busy_wait_max", int'(busy_o), 1);
      max_valid_i = 1;
    end
    k = 0;
    while (ack_n == 0 && k < 20) begin step; k++; end
    chk("max_ack_once", ack_n, 1);
    max_valid_i = 0;
    if (bp) begin
      k = 0;
      while (t_d1en < 0 && k < 30) begin step; k++; end
      chk("bp_elem_valid", int'(t_d1en >= 0), 1);
      held = sif.sub_data1_o;
      repeat (10) begin
        step;
        chk("bp_no_outc", outc_n, 0);
        chk("bp_count", int'(sif.sub_count_o), 0);
        chk("bp_hold", int'(sif.sub_data1_o), int'(held));
        chk("bp_en", int'(sif.sub_data1_en_o), 1);
      end
      ds_ready_i = 1;
      step; step;
      chk("bp_resume", outc_n, 1);
    end
    if (restart) begin
      repeat (3) step;
      start_i = 1; vec_len_i = 8'd3;
      step;
      start_i = 0;
    end
    k = 0;
    while (done_n == 0 && k < 3000) begin
      ds_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      step; k++;
    end
    ds_ready_i = 1;
    step; step;
    last = len - 1;
    chk("done_once", done_n, 1);
    chk("busy_after", int'(busy_o), 0);
    chk("d2_once", d2_n, 1);
    chk("d2_after_ack", t_d2 - t_ack, 1);
    chk("res_count", res_q.size(), len);
    chk("rd_count", rd_q.size(), len);
    chk("count_end", int'(sif.sub_count_o), len);
    chk("done_timing", done_cyc - qat(res_cyc, last), 1);
    for (int i = 0; i < len; i++) begin
      chk("res_data", qat(res_q, i), int'(ref_sub(mem[i], mx)));
      chk("res_last", qat(lst_q, i), int'(i == last));
      chk("rd_addr", qat(rd_q, i), i);
    end
    if (tim) begin
      chk("t_ack", t_ack - t_start, 1);
      chk("t_d2", t_d2 - t_start, 2);
      chk("t_rd0", qat(rd_cyc, 0) - t_start, 3);
      chk("t_d1en", t_d1en - t_start, 5);
      chk("rd_gap", qat(rd_cyc, 1) - qat(rd_cyc, 0), 4);
      chk("res_vs_rd", qat(res_cyc, 0), qat(rd_cyc, 1));
    end
  endtask

  initial begin
    int len;
    int k;
    logic [15:0] mx;
    rst_n = 0; start_i = 0; vec_len_i = '0;
    max_valid_i = 0; max_i = '0; ds_ready_i = 1;
    step; step;
    chk("reset_outs", int'(|outs()), 0);
    rst_n = 1;
    step;
    chk("idle_outs", int'(|outs()), 0);

    // basic
    mem[0] = 16'h0300; mem[1] = 16'h0100; mem[2] = 16'h0200;
    run_vec(3, 16'h0200, 0, 0, 0, 1, 0);
    chk("basic_r0", qat(res_q, 0), 'h0100);
    chk("basic_r1", qat(res_q, 1), 'hff00);
    chk("basic_r2", qat(res_q, 2), 'h0000);

    // saturation both ways
    mem[0] = 16'h8000;
    run_vec(1, 16'h0100, 0, 0, 0, 0, 0);
    chk("sat_neg", qat(res_q, 0), 'h8000);
    mem[0] = 16'h7ff0;
    run_vec(1, 16'hff00, 0, 0, 0, 0, 0);
    chk("sat_pos", qat(res_q, 0), 'h7fff);

    // backpressure
    for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
    run_vec(4, 16'($urandom), 0, 0, 1, 0, 0);

    // late max plus ignored restart
    for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
    run_vec(4, 16'($urandom), 7, 0, 0, 0, 1);

    // zero length
    clr_gen++;
    step;
    start_i = 1; vec_len_i = 8'd0;
    step;
    start_i = 0;
    repeat (4) step;
    chk("zero_err", err_n, 1);
    chk("zero_busy", busy_n, 0);
    chk("zero_reads", rd_q.size(), 0);

    // randomized vectors, random downstream ready
    for (int v = 0; v < 6; v++) begin
      len = $urandom_range(1, 12);
      mx = 16'($urandom);
      for (int i = 0; i < len; i++) mem[i] = 16'($urandom);
      run_vec(len, mx, $urandom_range(0, 3), 1, 0, 0, 0);
    end

    // full-length vector
    for (int i = 0; i < 255; i++) mem[i] = 16'($urandom);
    run_vec(255, 16'($urandom), 0, 0, 0, 0, 0);

    // reset mid-stream
    for (int i = 0; i < 5; i++) mem[i] = 16'($urandom);
    clr_gen++;
    step;
    start_i = 1; vec_len_i = 8'd5;
    max_i = 16'h0040; max_valid_i = 1;
    step;
    start_i = 0;
    k = 0;
    while (ack_n == 0 && k < 20) begin step; k++; end
    max_valid_i = 0;
    k = 0;
    while (res_q.size() < 2 && k < 200) begin step; k++; end
    chk("mid_two_results", res_q.size(), 2);
    rst_n = 0;
    #1;
    chk("mid_reset_outs", int'(|outs()), 0);
    step;
    rst_n = 1;
    step;
    chk("post_reset_outs", int'(|outs()), 0);
    mem[0] = 16'($urandom);
    run_vec(1, 16'($urandom), 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
